tlul_sram_slave: RTL

TL-UL responder that terminates the slave socket of the TL-UL interconnect: it accepts Channel A requests (Get, PutFullData, PutPartialData) and returns Channel D responses (AccessAck, AccessAckData) backed by a word-addressed, byte-writable memory. It is the device end of the protocol, connected to the interconnect's `slave_a_*`/`slave_d_*` socket. It serves one outstanding transaction at a time, with a programmable wait-state count.

---
 rtl/tlul_pkg.sv | 19 +
 rtl/tlul_sram_mem.sv | 36 +++
 rtl/tlul_sram_slave.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/tlul_pkg.sv
// Shared TL-UL definitions for the SRAM responder.
// Holds the Channel A/D opcode encodings and the 2-bit responder FSM state encoding.
package tlul_pkg;

   // Channel A opcodes
   localparam logic [2:0] PUT_FULL    = 3'd0;
   localparam logic [2:0] PUT_PARTIAL = 3'd1;
   localparam logic [2:0] GET         = 3'd4;

   // Channel D opcodes
   localparam logic [2:0] ACK         = 3'd0;
   localparam logic [2:0] ACK_DATA    = 3'd1;

   // Responder FSM states
   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_WAIT     = 2'd1;
   localparam logic [1:0] ST_RESP     = 2'd2;

endpackage

// File: rtl/tlul_sram_mem.sv
// Single-port word memory with per-byte write enables.
// Writes are synchronous, and reads are combinational. There is no reset.
// Ports:
//   clk   - clock
//   we    - write enable
//   be    - byte-lane enables, one per byte
//   idx   - word index
//   wdata - write data
//   rdata - read data for idx
module tlul_sram_mem #(
   parameter int unsigned MEM_DEPTH = 256,
   parameter int unsigned IDX_W     = $clog2(MEM_DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [3:0]       be,
   input  logic [IDX_W-1:0] idx,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata
);

   logic [31:0] mem [MEM_DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) begin
               mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
      end
   end

   assign rdata = mem[idx];

endmodule

// File: rtl/tlul_sram_slave.sv
// TL-UL device-side responder backed by a byte-writable word memory.
// It handles one transaction at a time and inserts a programmable number of wait states.
// Ports:
//   clk, reset      - rising-edge clock and synchronous active-low reset
//   a_valid/a_ready - Channel A handshake; a_ready is high only in IDLE
//   a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data - request fields
//   d_valid/d_ready - Channel D handshake
//   d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error - response fields
module tlul_sram_slave
   import tlul_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH   = 32,
   parameter int unsigned           DATA_WIDTH   = 32,
   parameter int unsigned           MASK_WIDTH   = DATA_WIDTH / 8,
   parameter int unsigned           SIZE_WIDTH   = 3,
   parameter int unsigned           OPCODE_WIDTH = 3,
   parameter int unsigned           PARAM_WIDTH  = 3,
   parameter int unsigned           MEM_DEPTH    = 256,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 32'h0,
   parameter int unsigned           WAIT_CYCLES  = 0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    a_valid,
   output logic                    a_ready,
   input  logic [OPCODE_WIDTH-1:0] a_opcode,
   input  logic [PARAM_WIDTH-1:0]  a_param,
   input  logic [SIZE_WIDTH-1:0]   a_size,
   input  logic                    a_source,
   input  logic [ADDR_WIDTH-1:0]   a_address,
   input  logic [MASK_WIDTH-1:0]   a_mask,
   input  logic [DATA_WIDTH-1:0]   a_data,
   output logic                    d_valid,
   input  logic                    d_ready,
   output logic [OPCODE_WIDTH-1:0] d_opcode,
   output logic [PARAM_WIDTH-1:0]  d_param,
   output logic [SIZE_WIDTH-1:0]   d_size,
   output logic                    d_source,
   output logic                    d_sink,
   output logic [DATA_WIDTH-1:0]   d_data,
   output logic                    d_error
);

   localparam int unsigned IDX_W     = $clog2(MEM_DEPTH);
   localparam logic [7:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 8'(WAIT_CYCLES - 1) : 8'd0;

   logic [1:0]            state_q, state_d;
   logic [7:0]            cnt_q, cnt_d;
   logic                  a_fire;
   logic                  is_get, is_put, bad_op, bad_size, misaligned, in_range, err;
   logic [IDX_W-1:0]      word_idx;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  unused_a_param;

   assign unused_a_param = ^a_param;

   // a_ready is only high in IDLE and outside reset, so it also qualifies the memory write.
   assign a_fire = a_valid & a_ready & reset;

   // Error decode.
   assign is_get   = (a_opcode == GET);
   assign is_put   = (a_opcode == PUT_FULL) || (a_opcode == PUT_PARTIAL);
   assign bad_op   = !(is_get || is_put);
   assign bad_size = (a_size > SIZE_WIDTH'(2));

   always_comb begin
      misaligned = 1'b0;
      case (a_size)
         SIZE_WIDTH'(1): misaligned = a_address[0];
         SIZE_WIDTH'(2): misaligned = |a_address[1:0];
         default:        misaligned = 1'b0;
      endcase
   end

   // BASE_ADDR is aligned to the window size. The range check therefore reduces to
   // an upper-bit compare. The word index is the address bits just above the byte offset,
   // because subtracting BASE_ADDR cannot change those low bits.
   assign in_range = (a_address[ADDR_WIDTH-1:IDX_W+2] == BASE_ADDR[ADDR_WIDTH-1:IDX_W+2]);
   assign word_idx = a_address[IDX_W+1:2];
   assign err      = bad_op | bad_size | misaligned | ~in_range;

   tlul_sram_mem #(
      .MEM_DEPTH (MEM_DEPTH),
      .IDX_W     (IDX_W)
   ) u_mem (
      .clk   (clk),
      .we    (a_fire & is_put & ~err),
      .be    (a_mask),
      .idx   (word_idx),
      .wdata (a_data),
      .rdata (rdata)
   );

   // Next-state logic for the FSM and the wait counter.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (a_fire) begin
               if (WAIT_CYCLES > 0) begin
                  state_d = ST_WAIT;
                  cnt_d   = WAIT_LOAD;
               end else begin
                  state_d = ST_RESP;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == 8'd0) begin
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         ST_RESP: begin
            if (d_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // a_ready and d_valid are registered decodes of the next state.
   // This keeps them equal to the current state, and a_ready can still read 0 during reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         a_ready  <= 1'b0;
         d_valid  <= 1'b0;
         d_opcode <= '0;
         d_size   <= '0;
         d_source <= 1'b0;
         d_data   <= '0;
         d_error  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_ready <= (state_d == ST_IDLE);
         d_valid <= (state_d == ST_RESP);
         if (a_fire) begin
            d_opcode <= is_get ? ACK_DATA : ACK;
            d_size   <= a_size;
            d_source <= a_source;
            d_data   <= (is_get && !err) ? rdata : '0;
            d_error  <= err;
         end
      end
   end

   assign d_param = '0;
   assign d_sink  = 1'b0;

endmodule
